mac50_accum: RTL and testbench



---
 rtl/mac50_accum.sv | 162 ++++++++++++++++
 tb/tb_mac50_accum.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac50_accum.sv
// Signed 24x24 multiply-accumulate into a saturating 50-bit sum, feeding the
// output shifter/clipper. Operands arrive over valid/ready; the result leaves over valid/ready.
//
// state | meaning
// IDLE  | waiting for start; result of the previous sum stays on acc_out
// ACCUM | accepting operand pairs until the programmed count is reached
// DRAIN | last registered product is folded into the sum
// DONE  | result presented, held until out_ready
module mac50_accum #(
  parameter int AW   = 24,
  parameter int ACCW = 50,
  parameter int CW   = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   start,
  input  logic [CW-1:0]          count,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [AW-1:0]   a,
  input  logic signed [AW-1:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [ACCW-1:0] acc_out,
  output logic                   acc_ovf,
  output logic                   busy
);

  localparam int PW = 2 * AW;
  localparam logic [ACCW-1:0] SAT_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic [ACCW-1:0] SAT_MIN = {1'b1, {(ACCW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state;
  logic [CW-1:0]           remaining;
  logic signed [ACCW-1:0]  prod;
  logic                    pipe_valid;

  logic                    beat;
  logic                    start_ok;
  logic signed [PW-1:0]    a_ext;
  logic signed [PW-1:0]    b_ext;
  logic signed [PW-1:0]    prod_full;
  logic [ACCW-1:0]         prod_ext;
  logic [ACCW:0]           sum_wide;
  logic                    ovf_pos;
  logic                    ovf_neg;

  assign beat     = in_valid & in_ready;
  assign start_ok = start & (state == IDLE);

  assign a_ext     = {{(PW-AW){a[AW-1]}}, a};
  assign b_ext     = {{(PW-AW){b[AW-1]}}, b};
  assign prod_full = a_ext * b_ext;
  assign prod_ext  = {{(ACCW-PW){prod_full[PW-1]}}, prod_full};

  // One extra bit exposes signed overflow as a mismatch of the top two bits.
  assign sum_wide = {acc_out[ACCW-1], acc_out} + {prod[ACCW-1], prod};
  assign ovf_pos  = ~sum_wide[ACCW] &  sum_wide[ACCW-1];
  assign ovf_neg  =  sum_wide[ACCW] & ~sum_wide[ACCW-1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      remaining <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      remaining <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (count != '0) begin
              state     <= ACCUM;
              remaining <= count;
              in_ready  <= 1'b1;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            remaining <= remaining - CW'(1);
            if (remaining == CW'(1)) begin
              in_ready <= 1'b0;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          state     <= DONE;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Product register feeds the accumulator one cycle later; a beat and an add can overlap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_out    <= '0;
      acc_ovf    <= 1'b0;
      prod       <= '0;
      pipe_valid <= 1'b0;
    end else if (clear) begin
      acc_out    <= '0;
      acc_ovf    <= 1'b0;
      prod       <= '0;
      pipe_valid <= 1'b0;
    end else if (start_ok) begin
      acc_out    <= '0;
      acc_ovf    <= 1'b0;
      pipe_valid <= 1'b0;
    end else begin
      pipe_valid <= beat;
      if (beat) begin
        prod <= prod_ext;
      end
      if (pipe_valid) begin
        if (ovf_pos) begin
          acc_out <= SAT_MAX;
          acc_ovf <= 1'b1;
        end else if (ovf_neg) begin
          acc_out <= SAT_MIN;
          acc_ovf <= 1'b1;
        end else begin
          acc_out <= sum_wide[ACCW-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_mac50_accum.sv
// Directed bench for mac50_accum: hand-computed sums, saturation, stalls and aborts.
module tb_mac50_accum;

  logic               clock;
  logic               reset_n;
  logic               clear;
  logic               start;
  logic [7:0]         count;
  logic               in_valid;
  logic               in_ready;
  logic signed [23:0] a;
  logic signed [23:0] b;
  logic               out_valid;
  logic               out_ready;
  logic signed [49:0] acc_out;
  logic               acc_ovf;
  logic               busy;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [49:0] MAX50 = {1'b0, {49{1'b1}}};
  localparam logic [49:0] MIN50 = {1'b1, {49{1'b0}}};

  mac50_accum dut (
    .clock(clock), .reset_n(reset_n), .clear(clear), .start(start), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
    .acc_ovf(acc_ovf), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [7:0] n);
    start = 1'b1;
    count = n;
    tick();
    start = 1'b0;
    count = 8'd0;
  endtask

  task automatic send(input logic signed [23:0] av, input logic signed [23:0] bv);
    a = av;
    b = bv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_n(input int n, input logic signed [23:0] av, input logic signed [23:0] bv);
    for (int i = 0; i < n; i++) send(av, bv);
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, acc_ovf, busy} !== 4'b0000 || acc_out !== 50'd0) begin
      n_bad++;
      $display("FAIL reset_values: rdy=%b vld=%b ovf=%b busy=%b acc=%0d required all 0",
               in_ready, out_valid, acc_ovf, busy, acc_out);
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    do_start(8'd3);
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_ready: in_ready=%b busy=%b required 1 1", in_ready, busy);
    end
    send(24'sd1000, 24'sd2000);
    send(-24'sd5, 24'sd7);
    send(24'sd300, -24'sd4);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_drain: out_valid=%b in_ready=%b required 0 0", out_valid, in_ready);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || acc_out !== 50'sd1998765 || acc_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_result: vld=%b acc=%0d ovf=%b required 1 1998765 0",
               out_valid, acc_out, acc_ovf);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || acc_out !== 50'sd1998765) begin
      n_bad++;
      $display("FAIL basic_after_hs: vld=%b busy=%b acc=%0d required 0 0 1998765",
               out_valid, busy, acc_out);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    do_start(8'd4);
    send_n(4, -24'sd8388608, -24'sd8388608);
    tick();
    n_cmp++;
    if (acc_out !== 50'sd281474976710656 || acc_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_4x: acc=%0d ovf=%b required 281474976710656 0", acc_out, acc_ovf);
    end
    take_result();

    do_start(8'd5);
    send_n(5, -24'sd8388608, -24'sd8388608);
    tick();
    n_cmp++;
    if (acc_out !== 50'sd351843720888320 || acc_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_5x: acc=%0d ovf=%b required 351843720888320 0", acc_out, acc_ovf);
    end
    take_result();

    do_start(8'd8);
    send_n(8, -24'sd8388608, -24'sd8388608);
    tick();
    n_cmp++;
    if (acc_out !== MAX50 || acc_ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_pos: acc=%0d ovf=%b required %0d 1", acc_out, acc_ovf, MAX50);
    end
    take_result();

    do_start(8'd9);
    send_n(9, -24'sd8388608, 24'sd8388607);
    tick();
    n_cmp++;
    if (acc_out !== MIN50 || acc_ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_neg: acc=%h ovf=%b required %h 1", acc_out, acc_ovf, MIN50);
    end
    take_result();

    do_start(8'd9);
    send_n(8, -24'sd8388608, -24'sd8388608);
    send(-24'sd1, 24'sd1);
    tick();
    n_cmp++;
    if (acc_out !== 50'sd562949953421310 || acc_ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_continue: acc=%0d ovf=%b required 562949953421310 1", acc_out, acc_ovf);
    end
    take_result();

    do_start(8'd1);
    send(24'sd2, 24'sd3);
    tick();
    n_cmp++;
    if (acc_out !== 50'sd6 || acc_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_cleared: acc=%0d ovf=%b required 6 0", acc_out, acc_ovf);
    end
    take_result();
  endtask

  task automatic test_zero_count();
    start = 1'b1;
    count = 8'd0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_ready_pre: in_ready=%b required 0", in_ready);
    end
    tick();
    start = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || acc_out !== 50'sd0 || acc_ovf !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_result: vld=%b acc=%0d ovf=%b rdy=%b required 1 0 0 0",
               out_valid, acc_out, acc_ovf, in_ready);
    end
    take_result();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_after_hs: vld=%b rdy=%b busy=%b required 0 0 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_gapped_stall();
    // 12345*-678 + -4096*-4096 = -8369910 + 16777216
    do_start(8'd2);
    send(24'sd12345, -24'sd678);
    for (int i = 0; i < 3; i++) begin
      a = 24'sd77 + 24'(i);
      b = -24'sd99;
      start = (i == 1);
      count = 8'd7;
      tick();
    end
    start = 1'b0;
    send(-24'sd4096, -24'sd4096);
    a = 24'sd1000;
    b = 24'sd1000;
    in_valid = 1'b1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL gap_latency: out_valid=%b required 0 one cycle after last beat", out_valid);
    end
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || acc_out !== 50'sd8407306 || acc_ovf !== 1'b0) begin
        n_bad++;
        $display("FAIL gap_hold[%0d]: vld=%b acc=%0d ovf=%b required 1 8407306 0",
                 i, out_valid, acc_out, acc_ovf);
      end
      start = (i % 2 == 0);
      count = 8'd3;
      tick();
    end
    start = 1'b0;
    take_result();
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || acc_out !== 50'sd8407306) begin
      n_bad++;
      $display("FAIL gap_idle: vld=%b rdy=%b busy=%b acc=%0d required 0 0 0 8407306",
               out_valid, in_ready, busy, acc_out);
    end
  endtask

  task automatic test_abort();
    do_start(8'd4);
    send_n(2, 24'sd100, 24'sd100);
    clear = 1'b1;
    in_valid = 1'b1;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, busy, in_ready, acc_ovf} !== 4'b0000 || acc_out !== 50'sd0) begin
      n_bad++;
      $display("FAIL clear_state: vld=%b busy=%b rdy=%b ovf=%b acc=%0d required 0 0 0 0 0",
               out_valid, busy, in_ready, acc_ovf, acc_out);
    end
    tick();
    tick();
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || acc_out !== 50'sd0) begin
      n_bad++;
      $display("FAIL clear_no_result: vld=%b acc=%0d required 0 0", out_valid, acc_out);
    end
    do_start(8'd1);
    send(24'sd3, 24'sd3);
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || acc_out !== 50'sd9) begin
      n_bad++;
      $display("FAIL clear_restart: vld=%b acc=%0d required 1 9", out_valid, acc_out);
    end
    take_result();

    start = 1'b1;
    clear = 1'b1;
    count = 8'd2;
    tick();
    start = 1'b0;
    clear = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || acc_out !== 50'sd0) begin
      n_bad++;
      $display("FAIL start_clear: busy=%b rdy=%b acc=%0d required 0 0 0", busy, in_ready, acc_out);
    end

    do_start(8'd4);
    send_n(2, 24'sd100, 24'sd100);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, acc_ovf, busy} !== 4'b0000 || acc_out !== 50'd0) begin
      n_bad++;
      $display("FAIL async_reset: rdy=%b vld=%b ovf=%b busy=%b acc=%0d required all 0",
               in_ready, out_valid, acc_ovf, busy, acc_out);
    end
    tick();
    reset_n = 1'b1;
    tick();
    do_start(8'd1);
    send(24'sd3, 24'sd3);
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || acc_out !== 50'sd9 || acc_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_restart: vld=%b acc=%0d ovf=%b required 1 9 0", out_valid, acc_out, acc_ovf);
    end
    take_result();
  endtask

  initial begin
    reset_n   = 1'b0;
    clear     = 1'b0;
    start     = 1'b0;
    count     = 8'd0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_zero_count();
    test_gapped_stall();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
